// File: rtl/ex_issue_unit_if.sv
// Issue-stage bus: fetch-side instruction handshake, writeback port and the ID/EX
// operand/control bundle. The master drives requests, the issue unit is the slave.
interface ex_issue_unit_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [31:0]   instr;
  logic          in_valid;
  logic          in_ready;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] aluSrcA;
  logic [DW-1:0] aluSrcB;
  logic [1:0]    ctrl;
  logic          ex_valid;
  logic          ex_ready;
  logic [AW-1:0] ex_rd;
  logic          ex_regwrite;
  logic [DW-1:0] ex_brOff;
  logic          illegal;

  modport master (
    output instr, in_valid, wb_en, wb_addr, wb_data, ex_ready,
    input  in_ready, aluSrcA, aluSrcB, ctrl, ex_valid, ex_rd, ex_regwrite, ex_brOff, illegal
  );

  modport slave (
    input  instr, in_valid, wb_en, wb_addr, wb_data, ex_ready,
    output in_ready, aluSrcA, aluSrcB, ctrl, ex_valid, ex_rd, ex_regwrite, ex_brOff, illegal
  );
endinterface

// File: rtl/ex_issue_unit.sv
// Decode/issue stage: register file with pending-write scoreboard, hazard stall,
// write-through bypass from the writeback port, and a registered ID/EX output.
module ex_issue_unit #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input logic            clk,
  input logic            rst,
  ex_issue_unit_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;
  localparam logic [1:0] CTRL_BEQ = 2'b10;
  localparam logic [1:0] CTRL_BNE = 2'b11;

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd_field;
  logic [15:0]   imm;

  assign op       = bus.instr[31:26];
  assign funct    = bus.instr[5:0];
  assign rs       = bus.instr[21 +: AW];
  assign rt       = bus.instr[16 +: AW];
  assign rd_field = bus.instr[11 +: AW];
  assign imm      = bus.instr[15:0];

  logic is_add, is_sub, is_addi, is_beq, is_bne;
  logic legal, use_rt;

  assign is_add  = (op == OP_RTYPE) && (funct == FN_ADD);
  assign is_sub  = (op == OP_RTYPE) && (funct == FN_SUB);
  assign is_addi = (op == OP_ADDI);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign legal   = is_add || is_sub || is_addi || is_beq || is_bne;
  assign use_rt  = is_add || is_sub || is_beq || is_bne;

  logic [DW-1:0] imm_sext;
  logic [DW-1:0] br_off;
  assign imm_sext = {{(DW-16){imm[15]}}, imm};
  assign br_off   = {{(DW-18){imm[15]}}, imm, 2'b00};

  logic [1:0]    dec_ctrl;
  logic [AW-1:0] dec_rd;
  logic          dec_rw;

  always_comb begin
    dec_ctrl = CTRL_ADD;
    dec_rd   = '0;
    dec_rw   = 1'b0;
    if (is_add || is_sub) begin
      dec_ctrl = is_sub ? CTRL_SUB : CTRL_ADD;
      dec_rd   = rd_field;
      dec_rw   = 1'b1;
    end else if (is_addi) begin
      dec_rd   = rt;
      dec_rw   = 1'b1;
    end else if (is_beq) begin
      dec_ctrl = CTRL_BEQ;
    end else if (is_bne) begin
      dec_ctrl = CTRL_BNE;
    end
  end

  logic [DW-1:0]   rf_rd [NREG];
  logic [NREG-1:0] sb_vec;
  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] sb_set;
  logic [NREG-1:0] pend;
  logic            set_en;

  // Entry 0 is a constant: never written, never pending, never bypassed.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_rd[gi]  = '0;
        assign sb_vec[gi] = 1'b0;
        assign wb_hit[gi] = 1'b0;
        assign sb_set[gi] = 1'b0;
      end else begin : g_live
        logic [DW-1:0] data_q;
        logic          busy_q;

        assign wb_hit[gi] = bus.wb_en && (bus.wb_addr == AW'(gi));
        assign sb_set[gi] = set_en && (dec_rd == AW'(gi));

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
          end else begin
            if (wb_hit[gi]) data_q <= bus.wb_data;
            if (sb_set[gi]) busy_q <= 1'b1;
            else if (wb_hit[gi]) busy_q <= 1'b0;
          end
        end

        assign rf_rd[gi]  = data_q;
        assign sb_vec[gi] = busy_q;
      end
      assign pend[gi] = sb_vec[gi] && !wb_hit[gi];
    end
  endgenerate

  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  assign rs_val = wb_hit[rs] ? bus.wb_data : rf_rd[rs];
  assign rt_val = wb_hit[rt] ? bus.wb_data : rf_rd[rt];

  logic hazard, in_ready, xfer;
  assign hazard   = legal && (pend[rs] || (use_rt && pend[rt]) || ((dec_rd != '0) && pend[dec_rd]));
  assign in_ready = (!bus.ex_valid || bus.ex_ready) && !hazard;
  assign xfer     = bus.in_valid && in_ready;
  assign set_en   = xfer && legal && dec_rw && (dec_rd != '0);

  logic          ex_valid_q;
  logic [DW-1:0] src_a_q;
  logic [DW-1:0] src_b_q;
  logic [1:0]    ctrl_q;
  logic [AW-1:0] rd_q;
  logic          rw_q;
  logic [DW-1:0] br_q;
  logic          illegal_q;

  // Data fields only move on a legal transfer, so a stall or an empty slot holds them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      ctrl_q     <= CTRL_ADD;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      br_q       <= '0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= xfer && !legal;
      if (xfer && legal) begin
        ex_valid_q <= 1'b1;
        src_a_q    <= rs_val;
        src_b_q    <= is_addi ? imm_sext : rt_val;
        ctrl_q     <= dec_ctrl;
        rd_q       <= dec_rd;
        rw_q       <= dec_rw;
        br_q       <= (is_beq || is_bne) ? br_off : '0;
      end else if (bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.aluSrcA     = src_a_q;
  assign bus.aluSrcB     = src_b_q;
  assign bus.ctrl        = ctrl_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_regwrite = rw_q;
  assign bus.ex_brOff    = br_q;
  assign bus.illegal     = illegal_q;
endmodule

// File: doc/ex_issue_unit.md
Name: ex_issue_unit

Overview:
Decode-and-issue stage that produces the operand and control bus consumed by the execute ALU: aluSrcA, aluSrcB and the 2-bit ctrl (add/sub/beq/bne). It holds the 32-entry register file and a per-register pending-write scoreboard. It issues one instruction per cycle into a registered ID/EX output, using valid/ready handshakes on both sides. Writeback from the later stages returns through a dedicated write port.

Parameters:
DW, 32, datapath width; aluSrcA/aluSrcB/wb_data width
NREG, 32, register count; register address width AW = log2(NREG) = 5

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
instr  input  32  MIPS instruction word
in_valid  input  1  instr is valid this cycle
in_ready  output  1  unit accepts instr this cycle (combinational)
wb_en  input  1  register write-back strobe
wb_addr  input  AW  write-back destination
wb_data  input  DW  write-back data
aluSrcA  output  DW  registered operand A to execute
aluSrcB  output  DW  registered operand B to execute
ctrl  output  2  registered ALU op: 00 add, 01 sub, 10 beq, 11 bne
ex_valid  output  1  ID/EX register holds a valid instruction
ex_ready  input  1  execute consumes ID/EX contents this cycle
ex_rd  output  AW  destination register (0 for branches)
ex_regwrite  output  1  instruction writes ex_rd
ex_brOff  output  DW  branch offset, sign-extended imm shifted left by 2; 0 for non-branches
illegal  output  1  one-cycle pulse: an unsupported instruction was accepted and dropped

Behaviour:
- Reset (async, rst=1): ex_valid=0, aluSrcA=0, aluSrcB=0, ctrl=00, ex_rd=0, ex_regwrite=0, ex_brOff=0, illegal=0. All register-file entries and all scoreboard bits clear to 0. rst asserted mid-stream discards the in-flight instruction and all pending state.
- Decode:
  - R-type (op=0) funct 0x20 add: ctrl=00, A=R[rs], B=R[rt], rd=instr[15:11], regwrite=1.
  - R-type funct 0x22 sub: same as add except ctrl=01.
  - op 0x08 addi: ctrl=00, A=R[rs], B=sign-extended imm16, rd=rt, regwrite=1.
  - op 0x04 beq: ctrl=10, A=R[rs], B=R[rt], rd=0, regwrite=0, brOff=sext(imm)<<2.
  - op 0x05 bne: as beq but ctrl=11.
  - Any other op/funct is illegal.
- Source usage: rs is used by all legal instructions; rt is used as a source by add, sub, beq and bne only.
- Register 0 reads 0, ignores writes, and is never pending.
- Hazard: hazard=1 if any used source, or a nonzero destination, has its scoreboard bit set, unless wb_en=1 with wb_addr equal to that register this cycle. In that case the bit counts as clear, and a source read uses wb_data (write-through bypass).
- Handshake:
  - in_ready = (!ex_valid || ex_ready) && !hazard.
  - Transfer occurs when in_valid && in_ready. A legal instruction loads the ID/EX register (1-cycle latency) and sets ex_valid=1.
  - An illegal instruction is consumed and pulses illegal the next cycle. If ex_ready=1, ex_valid drops to 0; otherwise ex_valid holds.
  - If ex_valid && !ex_ready, all outputs hold stable.
  - If ex_ready && no transfer, ex_valid goes to 0 and the data outputs hold their last values.
- Scoreboard:
  - Set bit[rd] on transfer of an instruction with regwrite=1 and rd!=0.
  - Clear bit[wb_addr] on wb_en.
  - When both hit the same register in the same cycle, set wins.
  - WAW is prevented by the destination check, so at most one write per register is outstanding.
- Register file: write on wb_en when wb_addr!=0; reads are combinational with the bypass described above.
- Arithmetic: no overflow checking. Sign extension replicates imm[15]. brOff is formed modulo 2^DW.

Test Plan:
- Reset, then wb R1=5 and R2=3; issue add $3,$1,$2 (0x00221820) -> next cycle ex_valid=1, aluSrcA=5, aluSrcB=3, ctrl=00, ex_rd=3, ex_regwrite=1.
- addi $4,$0,-1 (0x2004FFFF) -> aluSrcA=0, aluSrcB=0xFFFFFFFF, ctrl=00, ex_rd=4.
- bne $1,$2,+4 (0x14220004) -> ctrl=11, aluSrcA=5, aluSrcB=3, ex_brOff=0x10, ex_regwrite=0.
- Issue add $3,$1,$2, then sub $5,$3,$1 -> in_ready=0 until wb_en with wb_addr=3 and wb_data=8. In that same cycle the transfer happens and aluSrcA=8.
- Hold ex_ready=0 for 3 cycles with in_valid=1 -> outputs stable and in_ready=0. Raise ex_ready -> the next instruction issues one cycle later with no instruction lost or duplicated.
- Issue illegal op 0x23 (lw) -> illegal pulses for one cycle and no scoreboard change. Assert rst mid-stall -> ex_valid=0 and a subsequent add using R3 issues immediately.
